// File: rtl/apb_quad_gen.sv
`default_nettype none
// ============================================================================
// apb_quad_gen : APB-programmed quadrature A/B pulse generator (Gray-code steps)
// Revision     : 1.0
// ============================================================================
module apb_quad_gen #(
  parameter int DIV_BITS = 16
) (
  input  logic        apb_clock,
  input  logic        apb_resetn,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [11:0] apb_paddr,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  output logic        quad_a,
  output logic        quad_b,
  output logic        busy,
  output logic        done_int
);

  localparam logic [11:0] C_ADDR_CTRL   = 12'h000;
  localparam logic [11:0] C_ADDR_DIV    = 12'h004;
  localparam logic [11:0] C_ADDR_COUNT  = 12'h008;
  localparam logic [11:0] C_ADDR_STAT   = 12'h00C;
  localparam logic [11:0] C_ADDR_POS    = 12'h010;
  localparam logic [11:0] C_ADDR_REMAIN = 12'h014;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DIV_BITS-1:0] r_div, r_div_cnt;
  logic [31:0]         r_count, r_remain, r_pos, r_prdata;
  logic [1:0]          r_phase, w_phase_nxt;
  logic                r_dir, r_cont, r_done, r_quad_a, r_quad_b;
  logic                r_start_pend, r_stop_pend;
  logic                w_wr, w_rd, w_wr_ctrl, w_wr_stat, w_idle;
  logic                w_step, w_launch, w_zero_done, w_last;

  assign w_wr      = apb_psel & apb_penable & apb_pwrite;
  assign w_rd      = apb_psel & ~apb_penable & ~apb_pwrite;
  assign w_wr_ctrl = w_wr && (apb_paddr == C_ADDR_CTRL);
  assign w_wr_stat = w_wr && (apb_paddr == C_ADDR_STAT);
  assign w_idle    = (r_state == ST_IDLE);

  // dir is frozen while running, so it doubles as the latched run direction
  assign w_phase_nxt = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);

  always_ff @(posedge apb_clock or negedge apb_resetn) begin
    if (!apb_resetn) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_launch    = 1'b0;
    w_zero_done = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start_pend) begin
          if ((r_count != 32'd0) || r_cont) begin
            w_state_nxt = ST_RUN;
            w_launch    = 1'b1;
          end else begin
            w_zero_done = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_stop_pend) begin
          w_state_nxt = ST_IDLE;
        end else if (r_div_cnt == r_div) begin
          w_step = 1'b1;
          if (!r_cont && (r_remain == 32'd1)) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_clock or negedge apb_resetn) begin
    if (!apb_resetn) begin
      r_div        <= '0;
      r_div_cnt    <= '0;
      r_count      <= '0;
      r_remain     <= '0;
      r_pos        <= '0;
      r_prdata     <= '0;
      r_phase      <= '0;
      r_dir        <= 1'b0;
      r_cont       <= 1'b0;
      r_done       <= 1'b0;
      r_quad_a     <= 1'b0;
      r_quad_b     <= 1'b0;
      r_start_pend <= 1'b0;
      r_stop_pend  <= 1'b0;
    end else begin
      // stop beats start in the same write; start is ignored while running
      r_start_pend <= w_wr_ctrl & apb_pwdata[0] & ~apb_pwdata[1] & w_idle;
      r_stop_pend  <= w_wr_ctrl & apb_pwdata[1];
      if (w_wr_ctrl && w_idle) begin
        r_dir  <= apb_pwdata[2];
        r_cont <= apb_pwdata[3];
      end
      if (w_wr && (apb_paddr == C_ADDR_DIV))   r_div   <= apb_pwdata[DIV_BITS-1:0];
      if (w_wr && (apb_paddr == C_ADDR_COUNT)) r_count <= apb_pwdata;

      if (w_wr && (apb_paddr == C_ADDR_POS) && w_idle) r_pos <= apb_pwdata;
      else if (w_step) r_pos <= r_dir ? (r_pos - 32'd1) : (r_pos + 32'd1);

      if (w_launch) r_remain <= r_count;
      else if (w_step && !r_cont) r_remain <= r_remain - 32'd1;

      if (w_launch) r_div_cnt <= '0;
      else if (r_state == ST_RUN) r_div_cnt <= w_step ? '0 : (r_div_cnt + DIV_BITS'(1));

      if (w_step) begin
        r_phase  <= w_phase_nxt;
        r_quad_a <= w_phase_nxt[1] ^ w_phase_nxt[0];
        r_quad_b <= w_phase_nxt[1];
      end

      if (w_last || w_zero_done) r_done <= 1'b1;
      else if (w_launch) r_done <= 1'b0;
      else if (w_wr_stat && apb_pwdata[1]) r_done <= 1'b0;

      if (w_rd) begin
        case (apb_paddr)
          C_ADDR_CTRL:   r_prdata <= {28'd0, r_cont, r_dir, 2'b00};
          C_ADDR_DIV:    r_prdata <= 32'(r_div);
          C_ADDR_COUNT:  r_prdata <= r_count;
          C_ADDR_STAT:   r_prdata <= {30'd0, r_done, (r_state == ST_RUN)};
          C_ADDR_POS:    r_prdata <= r_pos;
          C_ADDR_REMAIN: r_prdata <= r_remain;
          default:       r_prdata <= '0;
        endcase
      end
    end
  end

  assign apb_prdata = r_prdata;
  assign quad_a     = r_quad_a;
  assign quad_b     = r_quad_b;
  assign busy       = (r_state == ST_RUN);
  assign done_int   = r_done;

endmodule
`default_nettype wire
